// File: rtl/uart_avs_core.sv
// rtl/uart_avs_core.sv - Avalon-MM slave 8N1 UART with RX (0x00), TX (0x04) and STATUS (0x08) registers
// Define UART_RX_FIFO_EN for an RX_FIFO_DEPTH-entry RX FIFO; otherwise a single RX holding register.
module uart_avs_core #(
  parameter int CLKS_PER_BIT  = 434,
  parameter int RX_FIFO_DEPTH = 4
) (
  input  logic        avm_clk,
  input  logic        avm_rst_n,
  input  logic [4:0]  avs_address,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic        avs_waitrequest,
  input  logic        uart_rxd,
  output logic        uart_txd
);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

  logic        ack_r, rd_pop_r;
  logic        req, wr_ack, tx_wr, st_wr;
  logic [31:0] rd_mux;
  logic        fe_r, roe_r, toe_r;
  logic        rx_rrdy, rx_full, rx_push, rx_pop, rx_accept, rx_fe_set;
  logic [7:0]  rx_head;
  logic        unused_wd;

  assign unused_wd       = ^avs_writedata[31:8];
  assign req             = avs_read | avs_write;
  assign avs_waitrequest = req & ~ack_r;
  // A simultaneous read and write is treated as a read only.
  assign wr_ack = ack_r & avs_write & ~avs_read;
  assign tx_wr  = wr_ack & (avs_address == 5'h04);
  assign st_wr  = wr_ack & (avs_address == 5'h08);
  assign rx_pop = ack_r & avs_read & rd_pop_r;

  // ---------------- TX ----------------
  uart_state_t tx_state, tx_next;
  logic [15:0] tx_cnt;
  logic [2:0]  tx_bit;
  logic [7:0]  tx_shift, tx_hold;
  logic        tx_hold_v, tx_take, tx_done;

  assign tx_done = (tx_cnt == BIT_LAST);

  always_comb begin
    tx_next = tx_state;
    tx_take = 1'b0;
    uart_txd = 1'b1;
    case (tx_state)
      S_IDLE:  if (tx_hold_v) begin tx_take = 1'b1; tx_next = S_START; end
      S_START: begin uart_txd = 1'b0; if (tx_done) tx_next = S_DATA; end
      S_DATA:  begin uart_txd = tx_shift[0]; if (tx_done && tx_bit == 3'd7) tx_next = S_STOP; end
      S_STOP:  if (tx_done) begin
                 // Chain straight into the next start bit for a zero-gap frame.
                 if (tx_hold_v) begin tx_take = 1'b1; tx_next = S_START; end
                 else tx_next = S_IDLE;
               end
      default: tx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_hold   <= '0;
      tx_hold_v <= 1'b0;
    end else begin
      tx_state <= tx_next;
      tx_cnt   <= (tx_state == S_IDLE || tx_done) ? 16'd0 : tx_cnt + 16'd1;
      if (tx_take) begin
        tx_shift <= tx_hold;
        tx_bit   <= '0;
      end else if (tx_state == S_DATA && tx_done) begin
        tx_shift <= {1'b0, tx_shift[7:1]};
        tx_bit   <= tx_bit + 3'd1;
      end
      if (tx_take) tx_hold_v <= 1'b0;
      else if (tx_wr && !tx_hold_v) begin
        tx_hold_v <= 1'b1;
        tx_hold   <= avs_writedata[7:0];
      end
    end
  end

  // ---------------- RX ----------------
  uart_state_t rx_state, rx_next;
  logic        rxd_s1, rxd_s2, rxd_prev, rx_fall;
  logic [15:0] rx_cnt;
  logic [2:0]  rx_bit;
  logic [7:0]  rx_shift;

  assign rx_fall = rxd_prev & ~rxd_s2;

  always_comb begin
    rx_next   = rx_state;
    rx_push   = 1'b0;
    rx_fe_set = 1'b0;
    case (rx_state)
      S_IDLE:  if (rx_fall) rx_next = S_START;
      S_START: if (rx_cnt == HALF_LAST) rx_next = rxd_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (rx_cnt == BIT_LAST && rx_bit == 3'd7) rx_next = S_STOP;
      S_STOP:  if (rx_cnt == BIT_LAST) begin
                 rx_next   = S_IDLE;
                 rx_push   = rxd_s2;
                 rx_fe_set = ~rxd_s2;
               end
      default: rx_next = S_IDLE;
    endcase
  end

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      rxd_s1   <= 1'b1;
      rxd_s2   <= 1'b1;
      rxd_prev <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rxd_s1   <= uart_rxd;
      rxd_s2   <= rxd_s1;
      rxd_prev <= rxd_s2;
      rx_state <= rx_next;
      if (rx_state == S_IDLE || rx_next != rx_state || rx_cnt == BIT_LAST) rx_cnt <= '0;
      else rx_cnt <= rx_cnt + 16'd1;
      if (rx_state == S_IDLE) rx_bit <= '0;
      else if (rx_state == S_DATA && rx_cnt == BIT_LAST) begin
        rx_shift <= {rxd_s2, rx_shift[7:1]};
        rx_bit   <= rx_bit + 3'd1;
      end
    end
  end

  // A push into a full store still succeeds if a pop frees the slot in the same cycle.
  assign rx_accept = rx_push & (~rx_full | rx_pop);

`ifdef UART_RX_FIFO_EN
  localparam int AW = $clog2(RX_FIFO_DEPTH);
  logic [7:0]    fifo_mem [RX_FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   fifo_cnt;

  assign rx_rrdy = (fifo_cnt != '0);
  assign rx_full = (fifo_cnt == (AW+1)'(RX_FIFO_DEPTH));
  assign rx_head = fifo_mem[rd_ptr];

  always_ff @(posedge avm_clk) begin
    if (rx_accept) fifo_mem[wr_ptr] <= rx_shift;
  end

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (rx_accept) wr_ptr <= wr_ptr + 1'b1;
      if (rx_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({rx_accept, rx_pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end
`else
  logic [7:0] rx_hold;
  logic       rx_hold_v;

  assign rx_rrdy = rx_hold_v;
  assign rx_full = rx_hold_v;
  assign rx_head = rx_hold;

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      rx_hold   <= '0;
      rx_hold_v <= 1'b0;
    end else if (rx_accept) begin
      rx_hold   <= rx_shift;
      rx_hold_v <= 1'b1;
    end else if (rx_pop) begin
      rx_hold_v <= 1'b0;
    end
  end
`endif

  // ---------------- Register file ----------------
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      5'h00:   if (rx_rrdy) rd_mux = {24'b0, rx_head};
      5'h08:   rd_mux = {24'b0, rx_rrdy, ~tx_hold_v, 1'b0, toe_r, roe_r, fe_r, 2'b0};
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge avm_clk) begin
    if (!avm_rst_n) begin
      ack_r        <= 1'b0;
      rd_pop_r     <= 1'b0;
      avs_readdata <= '0;
      fe_r         <= 1'b0;
      roe_r        <= 1'b0;
      toe_r        <= 1'b0;
    end else begin
      ack_r    <= req & ~ack_r;
      // Remember in the wait cycle whether the returned byte was real, so only that one is popped.
      rd_pop_r <= avs_waitrequest & avs_read & (avs_address == 5'h00) & rx_rrdy;
      if (avs_waitrequest && avs_read) avs_readdata <= rd_mux;
      fe_r  <= (fe_r  & ~(st_wr & avs_writedata[2])) | rx_fe_set;
      roe_r <= (roe_r & ~(st_wr & avs_writedata[3])) | (rx_push & rx_full & ~rx_pop);
      toe_r <= (toe_r & ~(st_wr & avs_writedata[4])) | (tx_wr & tx_hold_v);
    end
  end
endmodule
